// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports, their response channels and the shared RAM port.
// The arbiter uses the slave view; requesters and the RAM sit on the master view.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8
);
    localparam int SW = DATA_WIDTH / BYTE_WIDTH;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [SW-1:0]         req0_strobe;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [SW-1:0]         req1_strobe;
    logic [DATA_WIDTH-1:0] req1_wdata;

    logic                  resp0_valid;
    logic [DATA_WIDTH-1:0] resp0_data;
    logic                  resp1_valid;
    logic [DATA_WIDTH-1:0] resp1_data;

    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [SW-1:0]         ram_strobe;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  req0_valid, req0_addr, req0_strobe, req0_wdata,
        input  req1_valid, req1_addr, req1_strobe, req1_wdata,
        input  ram_rdata,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp1_valid, resp1_data,
        output ram_en, ram_addr, ram_strobe, ram_wdata
    );

    modport master (
        output req0_valid, req0_addr, req0_strobe, req0_wdata,
        output req1_valid, req1_addr, req1_strobe, req1_wdata,
        output ram_rdata,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp1_valid, resp1_data,
        input  ram_en, ram_addr, ram_strobe, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, read-first RAM.
// One access in flight: IDLE -> ACCESS -> WAIT x READ_LATENCY -> RESP -> IDLE.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);
    localparam int SW = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_gid;
    logic [1:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SW-1:0]         r_ram_strobe;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ram_en;
    logic [1:0]            r_resp_valid;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_grant0;
    logic w_grant1;
    logic w_capture;

    // On a tie the port that did not win last time goes first.
    assign w_grant0 = (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1 = (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    assign w_capture = ((r_state == ACCESS) && (READ_LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == 2'd1));

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.resp0_valid = r_resp_valid[0];
    assign bus.resp1_valid = r_resp_valid[1];
    assign bus.resp0_data  = r_rdata0;
    assign bus.resp1_data  = r_rdata1;
    assign bus.ram_en      = r_ram_en;
    assign bus.ram_addr    = r_addr;
    assign bus.ram_strobe  = r_ram_strobe;
    assign bus.ram_wdata   = r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_gid        <= 1'b0;
            r_cnt        <= 2'd0;
            r_addr       <= '0;
            r_ram_strobe <= '0;
            r_wdata      <= '0;
            r_ram_en     <= 1'b0;
            r_resp_valid <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_gid        <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_addr       <= w_grant1 ? bus.req1_addr   : bus.req0_addr;
                        r_ram_strobe <= w_grant1 ? bus.req1_strobe : bus.req0_strobe;
                        r_wdata      <= w_grant1 ? bus.req1_wdata  : bus.req0_wdata;
                        r_ram_en     <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ram_en     <= 1'b0;
                    r_ram_strobe <= '0;
                    r_cnt        <= 2'(READ_LATENCY);
                    r_state      <= WAIT;
                end
                WAIT: r_cnt <= r_cnt - 2'd1;
                RESP: begin
                    r_resp_valid <= 2'b00;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Capture overrides the WAIT transition above when the data is ready.
            if (w_capture) begin
                if (r_gid) r_rdata1 <= bus.ram_rdata;
                else       r_rdata0 <= bus.ram_rdata;
                r_resp_valid[r_gid] <= 1'b1;
                r_state             <= RESP;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (latency 1, 0, 3) on read-first RAM models,
// checked against an array memory model and the grant/latency rules.
module tb_ram_port_arbiter;
    typedef struct {
        int          c;
        int          p;
        logic [63:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  t_v  [3];
    logic [9:0]  t_a  [3][2];
    logic [7:0]  t_s  [3][2];
    logic [63:0] t_d  [3][2];
    logic [1:0]  o_rdy[3];
    logic [1:0]  o_rv [3];
    logic [63:0] o_rd [3][2];
    logic        o_en [3];
    logic [9:0]  o_addr[3];
    logic [7:0]  o_strb[3];
    logic [63:0] o_wd [3];
    int          en_cnt[3];

    logic [63:0] ref_mem [3][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] w, logic [7:0] s);
        logic [63:0] r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    // Reference memory: returns pre-access word, then applies the write.
    function automatic logic [63:0] model_access(int k, logic [9:0] a, logic [7:0] s, logic [63:0] w);
        logic [63:0] old = ref_mem[k][a];
        ref_mem[k][a] = merge(old, w, s);
        return old;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int L = (k == 0) ? 1 : (k == 1) ? 0 : 3;
        ram_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .BYTE_WIDTH(8)) bus ();
        ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .BYTE_WIDTH(8), .READ_LATENCY(L)) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );
        assign bus.req0_valid  = t_v[k][0];
        assign bus.req0_addr   = t_a[k][0];
        assign bus.req0_strobe = t_s[k][0];
        assign bus.req0_wdata  = t_d[k][0];
        assign bus.req1_valid  = t_v[k][1];
        assign bus.req1_addr   = t_a[k][1];
        assign bus.req1_strobe = t_s[k][1];
        assign bus.req1_wdata  = t_d[k][1];
        assign o_rdy[k]   = {bus.req1_ready, bus.req0_ready};
        assign o_rv[k]    = {bus.resp1_valid, bus.resp0_valid};
        assign o_rd[k][0] = bus.resp0_data;
        assign o_rd[k][1] = bus.resp1_data;
        assign o_en[k]    = bus.ram_en;
        assign o_addr[k]  = bus.ram_addr;
        assign o_strb[k]  = bus.ram_strobe;
        assign o_wd[k]    = bus.ram_wdata;

        logic [63:0] mem [1024];
        logic [63:0] pipe [3];
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = '0;
            for (int i = 0; i < 3; i++) pipe[i] = '0;
        end
        always @(posedge clk) begin
            if (bus.ram_en) begin
                pipe[0]           <= mem[bus.ram_addr];
                mem[bus.ram_addr] <= merge(mem[bus.ram_addr], bus.ram_wdata, bus.ram_strobe);
            end
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        if (L == 0) begin : g_comb
            assign bus.ram_rdata = mem[bus.ram_addr];
        end else begin : g_reg
            assign bus.ram_rdata = pipe[L-1];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) if (o_en[k]) en_cnt[k] <= en_cnt[k] + 1;
    end

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            t_v[k] = 2'b00;
            for (int p = 0; p < 2; p++) begin
                t_a[k][p] = '0; t_s[k][p] = '0; t_d[k][p] = '0;
            end
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Present a request and hold it until the handshake; acc = cycle of acceptance.
    task automatic do_req(input int k, input int p, input logic [9:0] a, input logic [7:0] s,
                          input logic [63:0] w, output int acc, output logic ok);
        @(posedge clk); #1;
        t_a[k][p] = a; t_s[k][p] = s; t_d[k][p] = w; t_v[k][p] = 1'b1;
        ok = 1'b0; acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_rdy[k][p]) begin acc = cyc; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        t_v[k][p] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input int p, output int rc, output logic [63:0] d, output logic ok);
        ok = 1'b0; rc = -1; d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_rv[k][p]) begin rc = cyc; d = o_rd[k][p]; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_rdy[k] !== 2'b00) begin errors++; $display("FAIL reset_ready k=%0d got %b want 00", k, o_rdy[k]); end
            checks++; if (o_rv[k] !== 2'b00) begin errors++; $display("FAIL reset_resp_valid k=%0d got %b want 00", k, o_rv[k]); end
            checks++; if (o_en[k] !== 1'b0 || o_strb[k] !== 8'h00) begin errors++; $display("FAIL reset_ram_en k=%0d got en=%b strb=%h want 0", k, o_en[k], o_strb[k]); end
            checks++; if (o_addr[k] !== 10'h0 || o_wd[k] !== 64'h0) begin errors++; $display("FAIL reset_ram_fields k=%0d got addr=%h wdata=%h want 0", k, o_addr[k], o_wd[k]); end
            checks++; if (o_rd[k][0] !== 64'h0 || o_rd[k][1] !== 64'h0) begin errors++; $display("FAIL reset_resp_data k=%0d got %h/%h want 0", k, o_rd[k][0], o_rd[k][1]); end
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_write_read();
        int acc, rc; logic ok, ok2; logic [63:0] d, exp;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            exp = model_access(k, 10'h005, 8'hFF, 64'h1122334455667788);
            do_req(k, 0, 10'h005, 8'hFF, 64'h1122334455667788, acc, ok);
            wait_resp(k, 0, rc, d, ok2);
            checks++; if (!ok || !ok2 || rc - acc != lat(k) + 2) begin errors++; $display("FAIL write_latency L=%0d got %0d want %0d", lat(k), rc - acc, lat(k) + 2); end
            checks++; if (d !== exp) begin errors++; $display("FAIL write_resp_data L=%0d got %h want %h", lat(k), d, exp); end
            exp = model_access(k, 10'h005, 8'h00, 64'h0);
            do_req(k, 0, 10'h005, 8'h00, 64'hFFFF_0000_FFFF_0000, acc, ok);
            wait_resp(k, 0, rc, d, ok2);
            checks++; if (!ok || !ok2 || rc - acc != lat(k) + 2) begin errors++; $display("FAIL read_latency L=%0d got %0d want %0d", lat(k), rc - acc, lat(k) + 2); end
            checks++; if (d !== exp) begin errors++; $display("FAIL read_data L=%0d got %h want %h", lat(k), d, exp); end
        end
    endtask

    task automatic test_tie();
        int a0, a1, r0, r1, e0; logic k0, k1, q0, q1; logic [63:0] d0, d1, x0, x1;
        apply_reset();
        e0 = en_cnt[0];
        x0 = model_access(0, 10'h005, 8'h00, 64'h0);
        x1 = model_access(0, 10'h006, 8'h00, 64'h0);
        fork
            begin do_req(0, 0, 10'h005, 8'h00, 64'h0, a0, k0); wait_resp(0, 0, r0, d0, q0); end
            begin do_req(0, 1, 10'h006, 8'h00, 64'h0, a1, k1); wait_resp(0, 1, r1, d1, q1); end
        join
        repeat (2) @(posedge clk);
        checks++; if (!(k0 && k1 && q0 && q1) || a0 >= a1) begin errors++; $display("FAIL tie_first_grant got acc0=%0d acc1=%0d want port0 first", a0, a1); end
        checks++; if (a1 - a0 != 4) begin errors++; $display("FAIL tie_accept_gap got %0d want 4", a1 - a0); end
        checks++; if (r1 - r0 != 4 || r0 - a0 != 3) begin errors++; $display("FAIL tie_resp_gap got %0d/%0d want 4/3", r1 - r0, r0 - a0); end
        checks++; if (d0 !== x0 || d1 !== x1) begin errors++; $display("FAIL tie_data got %h/%h want %h/%h", d0, d1, x0, x1); end
        checks++; if (en_cnt[0] - e0 != 2) begin errors++; $display("FAIL tie_ram_en_count got %0d want 2", en_cnt[0] - e0); end
    endtask

    task automatic test_strobe();
        int acc, rc; logic ok, ok2; logic [63:0] d, exp;
        apply_reset();
        exp = model_access(0, 10'h010, 8'hFF, 64'h1122334455667788);
        do_req(0, 0, 10'h010, 8'hFF, 64'h1122334455667788, acc, ok);
        wait_resp(0, 0, rc, d, ok2);
        exp = model_access(0, 10'h010, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        do_req(0, 1, 10'h010, 8'h0F, 64'hAAAAAAAAAAAAAAAA, acc, ok);
        wait_resp(0, 1, rc, d, ok2);
        checks++; if (!ok2 || d !== 64'h1122334455667788) begin errors++; $display("FAIL strobe_write_resp got %h want 1122334455667788", d); end
        exp = model_access(0, 10'h010, 8'h00, 64'h0);
        do_req(0, 1, 10'h010, 8'h00, 64'h0, acc, ok);
        wait_resp(0, 1, rc, d, ok2);
        checks++; if (!ok2 || d !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL strobe_merge got %h want 11223344aaaaaaaa", d); end
        checks++; if (d !== exp) begin errors++; $display("FAIL strobe_model got %h want %h", d, exp); end
    endtask

    task automatic test_reset_mid();
        int acc, rc; logic ok, ok2; logic [63:0] d, exp;
        apply_reset();
        // Write aborted during its ACCESS cycle must never land in the RAM.
        do_req(0, 0, 10'h030, 8'hFF, 64'hDEADBEEFCAFEF00D, acc, ok);
        reset = 1'b1; #1;
        checks++; if (o_en[0] !== 1'b0) begin errors++; $display("FAIL abort_access_en got %b want 0", o_en[0]); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp = model_access(0, 10'h030, 8'h00, 64'h0);
        do_req(0, 0, 10'h030, 8'h00, 64'h0, acc, ok);
        wait_resp(0, 0, rc, d, ok2);
        checks++; if (!ok2 || d !== exp) begin errors++; $display("FAIL abort_write_leak got %h want %h", d, exp); end
        // Read aborted in WAIT: no response, port 0 ready right after release.
        do_req(0, 0, 10'h005, 8'h00, 64'h0, acc, ok);
        @(posedge clk); #1;
        reset = 1'b1;
        t_a[0][0] = 10'h007; t_s[0][0] = 8'h00; t_v[0][0] = 1'b1;
        #1;
        checks++; if (o_en[0] !== 1'b0 || o_rv[0] !== 2'b00) begin errors++; $display("FAIL abort_wait_outputs got en=%b rv=%b want 0/00", o_en[0], o_rv[0]); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (o_rv[0] !== 2'b00) begin errors++; $display("FAIL abort_no_resp got %b want 00", o_rv[0]); end
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (o_rdy[0] !== 2'b01) begin errors++; $display("FAIL abort_ready_after got %b want 01", o_rdy[0]); end
        acc = cyc;
        exp = model_access(0, 10'h007, 8'h00, 64'h0);
        @(posedge clk); #1 t_v[0][0] = 1'b0;
        wait_resp(0, 0, rc, d, ok2);
        checks++; if (!ok2 || rc - acc != 3 || d !== exp) begin errors++; $display("FAIL abort_next_access got lat=%0d data=%h want 3/%h", rc - acc, d, exp); end
    endtask

    task automatic test_rr();
        int ac[3]; int gp[4]; int n, m;
        ac = '{0, 0, 0}; gp = '{9, 9, 9, 9}; n = 0; m = 0;
        apply_reset();
        t_a[0][1] = 10'h008; t_v[0][1] = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (o_rdy[0][1]) begin ac[n] = cyc; n++; end
        end
        checks++; if (n != 3 || ac[1] - ac[0] != 4 || ac[2] - ac[1] != 4) begin errors++; $display("FAIL rr_single_spacing got n=%0d gaps=%0d,%0d want 3/4,4", n, ac[1] - ac[0], ac[2] - ac[1]); end
        @(posedge clk); #1;
        t_a[0][0] = 10'h009; t_v[0][0] = 1'b1;
        for (int i = 0; i < 60 && m < 4; i++) begin
            @(negedge clk);
            if (o_rdy[0][0]) begin gp[m] = 0; m++; end
            else if (o_rdy[0][1]) begin gp[m] = 1; m++; end
        end
        for (int j = 0; j < 4; j++) begin
            checks++; if (gp[j] != j % 2) begin errors++; $display("FAIL rr_alternate idx=%0d got %0d want %0d", j, gp[j], j % 2); end
        end
        @(posedge clk); #1 t_v[0] = 2'b00;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_random();
        exp_t q[$]; exp_t e;
        int last, prev_acc, L; logic [1:0] accf; logic [63:0] last_d[2];
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            L = lat(k); last = 1; prev_acc = -100; accf = 2'b00; q.delete();
            last_d[0] = '0; last_d[1] = '0;
            for (int c = 0; c < 400; c++) begin
                @(posedge clk); #1;
                for (int p = 0; p < 2; p++) begin
                    if (t_v[k][p] && (accf[p] || $urandom_range(0, 7) == 0)) t_v[k][p] = 1'b0;
                    if (!t_v[k][p] && c < 380 && $urandom_range(0, 1) == 1) begin
                        t_a[k][p] = 10'($urandom_range(0, 15));
                        t_s[k][p] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                        t_d[k][p] = {$urandom, $urandom};
                        t_v[k][p] = 1'b1;
                    end
                end
                @(negedge clk);
                accf = 2'b00;
                checks++; if ((o_rdy[k] & ~t_v[k]) != 2'b00 || o_rdy[k] == 2'b11) begin errors++; $display("FAIL rnd_ready L=%0d got %b valid %b", L, o_rdy[k], t_v[k]); end
                checks++; if (o_en[k] !== (cyc == prev_acc + 1) || (!o_en[k] && o_strb[k] !== 8'h00)) begin errors++; $display("FAIL rnd_ram_en L=%0d got en=%b strb=%h want en=%b", L, o_en[k], o_strb[k], cyc == prev_acc + 1); end
                for (int p = 0; p < 2; p++) begin
                    if (o_rdy[k][p] && t_v[k][p]) begin
                        accf[p] = 1'b1;
                        if (t_v[k] == 2'b11) begin
                            checks++; if (p == last) begin errors++; $display("FAIL rnd_round_robin L=%0d got port %0d want %0d", L, p, 1 - last); end
                        end
                        checks++; if (cyc - prev_acc < L + 3) begin errors++; $display("FAIL rnd_spacing L=%0d got %0d want >=%0d", L, cyc - prev_acc, L + 3); end
                        prev_acc = cyc; last = p;
                        e.c = cyc + L + 2; e.p = p; e.d = model_access(k, t_a[k][p], t_s[k][p], t_d[k][p]);
                        q.push_back(e);
                    end
                end
                if (q.size() > 0 && q[0].c < cyc) begin
                    errors++; checks++;
                    $display("FAIL rnd_missing_resp L=%0d port %0d due cycle %0d", L, q[0].p, q[0].c);
                    void'(q.pop_front());
                end
                for (int p = 0; p < 2; p++) begin
                    if (o_rv[k][p]) begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++; $display("FAIL rnd_spurious_resp L=%0d port %0d", L, p);
                        end else begin
                            e = q.pop_front();
                            if (e.p != p || e.c != cyc || o_rd[k][p] !== e.d) begin
                                errors++; $display("FAIL rnd_resp L=%0d got port %0d cyc %0d data %h want port %0d cyc %0d data %h", L, p, cyc, o_rd[k][p], e.p, e.c, e.d);
                            end
                        end
                        last_d[p] = o_rd[k][p];
                    end else begin
                        checks++; if (o_rd[k][p] !== last_d[p]) begin errors++; $display("FAIL rnd_data_hold L=%0d port %0d got %h want %h", L, p, o_rd[k][p], last_d[p]); end
                    end
                end
            end
            checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain L=%0d got %0d outstanding want 0", L, q.size()); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en_cnt[k] = 0;
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
        end
        clear_inputs();
        test_reset();
        test_write_read();
        test_tie();
        test_strobe();
        test_reset_mid();
        test_rr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
